// File: rtl/jtcop_obj_pkg.sv
// Shared definitions for the object RAM shadow-copy DMA: default geometry,
// FSM state encoding and the copy length helper.
package jtcop_obj_pkg;

    localparam int AW_DEF = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAITVB = 2'd1,
        COPY   = 2'd2,
        FLUSH  = 2'd3
    } dma_state_t;

    // Cycles from COPY entry to the done pulse: one read per word plus the flush.
    function automatic int copy_len(input int aw);
        return (1 << aw) + 1;
    endfunction

endpackage

// File: rtl/jtframe_dual_ram.sv
// Dual-port block RAM: port A read/write with byte enables, port B read-only.
// Both read ports are registered and return the pre-write contents on a collision.
module jtframe_dual_ram #(
    parameter int DW = 16,
    parameter int AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DW-1:0]     data_a,
    input  logic [AW-1:0]     addr_a,
    input  logic [DW/8-1:0]   we_a,
    output logic [DW-1:0]     q_a,
    input  logic [AW-1:0]     addr_b,
    output logic [DW-1:0]     q_b
);

    logic [DW-1:0] mem [0:2**AW-1];

    // NOTE: the array itself has no reset so it maps onto block RAM; only the
    // output registers are cleared.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DW/8; i++) begin
            if (we_a[i]) mem[addr_a][i*8 +: 8] <= data_a[i*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_a <= '0;
            q_b <= '0;
        end else begin
            q_a <= mem[addr_a];
            q_b <= mem[addr_b];
        end
    end

endmodule

// File: rtl/jtcop_obj_dma.sv
// Object RAM with a shadow copy: the CPU owns the live RAM, the renderer scans
// the shadow, and a DMA engine copies live into shadow on each copy request.
module jtcop_obj_dma
    import jtcop_obj_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter bit WAIT_VB = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          LVBL,
    input  logic          objram_cs,
    input  logic          obj_copy,
    input  logic [AW-1:0] cpu_addr,
    input  logic [15:0]   cpu_dout,
    input  logic [1:0]    cpu_dsn,
    input  logic          cpu_rnw,
    output logic [15:0]   obj_dout,
    input  logic [AW-1:0] scan_addr,
    output logic [15:0]   scan_data,
    output logic          busy,
    output logic          done
);

    dma_state_t    state, state_nxt;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   rd_ptr_nxt;
    logic [AW-1:0] wr_ptr;
    logic          wr_en;
    logic          pending;
    logic          obj_copy_l;
    logic          req;
    logic          copy_entry;
    logic [1:0]    cpu_we;
    logic [15:0]   dma_data;
    logic [15:0]   shadow_q_unused;

    assign req        = obj_copy & ~obj_copy_l;
    assign cpu_we     = {2{objram_cs & ~cpu_rnw}} & ~cpu_dsn;
    assign rd_ptr_nxt = rd_ptr + (AW+1)'(1);
    assign copy_entry = (state_nxt == COPY) && (state != COPY);
    assign busy       = (state != IDLE) | pending;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            IDLE:   if (req || pending) state_nxt = (WAIT_VB && LVBL) ? WAITVB : COPY;
            WAITVB: if (!LVBL) state_nxt = COPY;
            COPY:   if (rd_ptr_nxt[AW]) state_nxt = FLUSH;
            FLUSH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            wr_en      <= 1'b0;
            pending    <= 1'b0;
            obj_copy_l <= 1'b1;   // a strobe held through reset is not an edge
        end else begin
            obj_copy_l <= obj_copy;
            state      <= state_nxt;
            // Writeback trails the live read by one cycle, the FLUSH cycle
            // retires the final word.
            wr_en      <= (state == COPY);
            wr_ptr     <= rd_ptr[AW-1:0];
            if (copy_entry)          rd_ptr <= '0;
            else if (state == COPY)  rd_ptr <= rd_ptr_nxt;
            if (copy_entry)                  pending <= 1'b0;
            else if (req && state != IDLE)   pending <= 1'b1;
        end
    end

    jtframe_dual_ram #(.DW(16), .AW(AW)) u_live (
        .clk    (clk),
        .rst    (rst),
        .data_a (cpu_dout),
        .addr_a (cpu_addr),
        .we_a   (cpu_we),
        .q_a    (obj_dout),
        .addr_b (rd_ptr[AW-1:0]),
        .q_b    (dma_data)
    );

    jtframe_dual_ram #(.DW(16), .AW(AW)) u_shadow (
        .clk    (clk),
        .rst    (rst),
        .data_a (dma_data),
        .addr_a (wr_ptr),
        .we_a   ({2{wr_en}}),
        .q_a    (shadow_q_unused),
        .addr_b (scan_addr),
        .q_b    (scan_data)
    );

endmodule
